// File: rtl/gat_pkg.sv
// ============================================================================
// Module   : gat_pkg
// Brief    : WH word field layout, width helpers and subgraph FSM states.
// Revision : 1.0
// ============================================================================
`default_nettype none

package gat_pkg;

    // WH word layout: {results, num_node, src_flag}
    localparam int FLAG_BIT     = 0;
    localparam int NUM_NODE_LSB = 1;

    typedef enum logic [0:0] {
        SG_IDLE  = 1'b0,
        SG_IN_SG = 1'b1
    } sg_state_t;

    function automatic int f_node_w(input int max_nodes);
        return $clog2(max_nodes);
    endfunction

    function automatic int f_addr_w(input int total_nodes);
        return $clog2(total_nodes);
    endfunction

    function automatic int f_res_lsb(input int max_nodes);
        return $clog2(max_nodes) + 1;
    endfunction

    function automatic int f_wh_width(input int data_w, input int num_feat, input int max_nodes);
        return data_w * num_feat + $clog2(max_nodes) + 1;
    endfunction

endpackage : gat_pkg

`default_nettype wire

// File: rtl/wh_fifo.sv
// ============================================================================
// Module   : wh_fifo
// Brief    : Synchronous FIFO with registered valid / almost-full / full flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wh_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_data,
    output logic             o_almost_full,
    output logic             o_ovf
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic [AW:0]      w_count_nxt;
    logic             r_vld;
    logic             r_full;
    logic             r_afull;
    logic             w_pop;
    logic             w_push;

    // A pop in the same cycle frees the slot, so a push into a full FIFO is
    // only dropped when nothing leaves.
    assign w_pop  = i_pop & r_vld;
    assign w_push = i_push & (~r_full | w_pop);
    assign o_ovf  = i_push & r_full & ~w_pop;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + (AW+1)'(1);
            2'b01:   w_count_nxt = r_count - (AW+1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_vld   <= 1'b0;
            r_full  <= 1'b0;
            r_afull <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= w_count_nxt;
            r_vld   <= (w_count_nxt != '0);
            r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
            r_afull <= (w_count_nxt >= (AW+1)'(DEPTH-1));
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

    assign o_vld         = r_vld;
    assign o_data        = r_vld ? r_mem[r_rptr] : '0;
    assign o_almost_full = r_afull;

endmodule : wh_fifo

`default_nettype wire

// File: rtl/wh_collector.sv
// ============================================================================
// Module   : wh_collector
// Brief    : Packs completed PE rows into WH words, writes the WH BRAM, feeds
//            the DMVM FIFO and tracks subgraph boundaries.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wh_collector
    import gat_pkg::*;
#(
    parameter int WH_DATA_WIDTH   = 12,
    parameter int NUM_FEATURE_OUT = 16,
    parameter int MAX_NODES       = 168,
    parameter int TOTAL_NODES     = 13264,
    parameter int NUM_SUBGRAPHS   = 2708,
    parameter int FIFO_DEPTH      = 4,
    localparam int NUM_NODE_WIDTH  = f_node_w(MAX_NODES),
    localparam int WH_ADDR_W       = f_addr_w(TOTAL_NODES),
    localparam int SG_CNT_W        = $clog2(NUM_SUBGRAPHS + 1),
    localparam int WH_RESULT_WIDTH = WH_DATA_WIDTH * NUM_FEATURE_OUT,
    localparam int WH_WIDTH        = f_wh_width(WH_DATA_WIDTH, NUM_FEATURE_OUT, MAX_NODES)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       row_vld_i,
    input  logic [WH_RESULT_WIDTH-1:0] res_i,
    input  logic [NUM_NODE_WIDTH-1:0]  num_node_i,
    input  logic                       src_flag_i,
    output logic                       wh_ena,
    output logic                       wh_wea,
    output logic [WH_ADDR_W-1:0]       wh_addra,
    output logic [WH_WIDTH-1:0]        wh_dina,
    output logic                       wh_vld_o,
    output logic [WH_WIDTH-1:0]        wh_data_o,
    input  logic                       wh_rdy_i,
    output logic                       stall_o,
    output logic                       sg_done_o,
    output logic [SG_CNT_W-1:0]        sg_cnt_o,
    output logic                       done_o,
    output logic                       seq_err_o,
    output logic                       ovf_err_o
);

    localparam int RES_LSB = f_res_lsb(MAX_NODES);
    localparam logic [WH_ADDR_W-1:0] LAST_ADDR = WH_ADDR_W'(TOTAL_NODES - 1);
    localparam logic [SG_CNT_W-1:0]  SG_MAX    = SG_CNT_W'(NUM_SUBGRAPHS);

    // Write-side pipeline
    logic                      r_wr_vld;
    logic [WH_ADDR_W-1:0]      r_wr_addr;
    logic [WH_WIDTH-1:0]       r_wr_data;
    logic [WH_ADDR_W-1:0]      r_next_addr;
    logic                      r_exhausted;
    logic                      r_done;
    logic                      w_accept;
    logic [WH_WIDTH-1:0]       w_word;

    // Subgraph tracking
    sg_state_t                 r_state;
    sg_state_t                 w_state_nxt;
    logic [NUM_NODE_WIDTH-1:0] r_node_cnt;
    logic [NUM_NODE_WIDTH-1:0] w_node_cnt_nxt;
    logic [NUM_NODE_WIDTH-1:0] r_num_node;
    logic [NUM_NODE_WIDTH-1:0] w_num_node_nxt;
    logic                      w_seq_err;
    logic                      w_sg_end;
    logic                      r_sg_done;
    logic [SG_CNT_W-1:0]       r_sg_cnt;
    logic                      r_seq_err;
    logic                      r_ovf_err;
    logic                      w_fifo_ovf;
    logic                      w_fifo_afull;

    // Exhaustion is tracked at accept time so a row arriving on the same edge
    // that the last write completes is already refused.
    assign w_accept = row_vld_i & ~r_exhausted;

    always_comb begin
        w_word = '0;
        w_word[RES_LSB +: WH_RESULT_WIDTH]       = res_i;
        w_word[NUM_NODE_LSB +: NUM_NODE_WIDTH]   = num_node_i;
        w_word[FLAG_BIT]                         = src_flag_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_vld    <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_next_addr <= '0;
            r_exhausted <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_wr_vld <= w_accept;
            if (w_accept) begin
                r_wr_addr   <= r_next_addr;
                r_wr_data   <= w_word;
                r_next_addr <= r_next_addr + WH_ADDR_W'(1);
                if (r_next_addr == LAST_ADDR) r_exhausted <= 1'b1;
            end
            if (r_wr_vld && (r_wr_addr == LAST_ADDR)) r_done <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_node_cnt_nxt = r_node_cnt;
        w_num_node_nxt = r_num_node;
        w_seq_err      = 1'b0;
        w_sg_end       = 1'b0;
        if (w_accept) begin
            if (src_flag_i) begin
                w_seq_err      = (r_state == SG_IN_SG);
                w_node_cnt_nxt = NUM_NODE_WIDTH'(1);
                w_num_node_nxt = (num_node_i == '0) ? NUM_NODE_WIDTH'(1) : num_node_i;
            end else if (r_state == SG_IDLE) begin
                w_seq_err = 1'b1;
            end else begin
                w_node_cnt_nxt = r_node_cnt + NUM_NODE_WIDTH'(1);
            end
            if (src_flag_i || (r_state == SG_IN_SG)) begin
                if (w_node_cnt_nxt == w_num_node_nxt) begin
                    w_sg_end    = 1'b1;
                    w_state_nxt = SG_IDLE;
                end else begin
                    w_state_nxt = SG_IN_SG;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= SG_IDLE;
            r_node_cnt <= '0;
            r_num_node <= '0;
            r_sg_done  <= 1'b0;
            r_sg_cnt   <= '0;
            r_seq_err  <= 1'b0;
            r_ovf_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_node_cnt <= w_node_cnt_nxt;
            r_num_node <= w_num_node_nxt;
            r_sg_done  <= w_sg_end;
            if (r_sg_done && (r_sg_cnt != SG_MAX)) r_sg_cnt <= r_sg_cnt + SG_CNT_W'(1);
            if (w_seq_err)  r_seq_err <= 1'b1;
            if (w_fifo_ovf) r_ovf_err <= 1'b1;
        end
    end

    wh_fifo #(
        .WIDTH (WH_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_push        (r_wr_vld),
        .i_data        (r_wr_data),
        .i_pop         (wh_rdy_i),
        .o_vld         (wh_vld_o),
        .o_data        (wh_data_o),
        .o_almost_full (w_fifo_afull),
        .o_ovf         (w_fifo_ovf)
    );

    assign wh_ena    = r_wr_vld;
    assign wh_wea    = r_wr_vld;
    assign wh_addra  = r_wr_addr;
    assign wh_dina   = r_wr_data;
    assign stall_o   = w_fifo_afull;
    assign sg_done_o = r_sg_done;
    assign sg_cnt_o  = r_sg_cnt;
    assign done_o    = r_done;
    assign seq_err_o = r_seq_err;
    assign ovf_err_o = r_ovf_err;

endmodule : wh_collector

`default_nettype wire

// File: tb/tb_wh_collector.sv
// ============================================================================
// Module   : tb_wh_collector
// Brief    : Randomised scoreboard bench for wh_collector.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wh_collector;

    localparam int DW    = 12;
    localparam int NF    = 16;
    localparam int MAXN  = 168;
    localparam int TOTAL = 24;
    localparam int NSG   = 2708;
    localparam int DEPTH = 4;
    localparam int NW    = $clog2(MAXN);
    localparam int AW    = $clog2(TOTAL);
    localparam int SW    = $clog2(NSG + 1);
    localparam int RW    = DW * NF;
    localparam int WW    = RW + NW + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
        logic          sg_done;
        logic          seq_err;
        int            cyc;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          row_vld_i = 1'b0;
    logic [RW-1:0] res_i = '0;
    logic [NW-1:0] num_node_i = '0;
    logic          src_flag_i = 1'b0;
    logic          wh_rdy_i = 1'b0;
    logic          wh_ena, wh_wea, wh_vld_o, stall_o, sg_done_o, done_o, seq_err_o, ovf_err_o;
    logic [AW-1:0] wh_addra;
    logic [WW-1:0] wh_dina, wh_data_o;
    logic [SW-1:0] sg_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    wr_t           q_wr[$];
    logic [WW-1:0] m_fifo[$];
    logic          m_done = 1'b0;
    logic          m_ovf  = 1'b0;
    int            m_sgcnt = 0;

    // Stimulus-side view of the spec: rows accepted so far and subgraph progress
    int   s_acc = 0;
    bit   s_in_sg = 0;
    int   s_cnt = 0;
    int   s_target = 0;
    logic s_seq = 1'b0;

    wh_collector #(
        .WH_DATA_WIDTH   (DW),
        .NUM_FEATURE_OUT (NF),
        .MAX_NODES       (MAXN),
        .TOTAL_NODES     (TOTAL),
        .NUM_SUBGRAPHS   (NSG),
        .FIFO_DEPTH      (DEPTH)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .row_vld_i  (row_vld_i),
        .res_i      (res_i),
        .num_node_i (num_node_i),
        .src_flag_i (src_flag_i),
        .wh_ena     (wh_ena),
        .wh_wea     (wh_wea),
        .wh_addra   (wh_addra),
        .wh_dina    (wh_dina),
        .wh_vld_o   (wh_vld_o),
        .wh_data_o  (wh_data_o),
        .wh_rdy_i   (wh_rdy_i),
        .stall_o    (stall_o),
        .sg_done_o  (sg_done_o),
        .sg_cnt_o   (sg_cnt_o),
        .done_o     (done_o),
        .seq_err_o  (seq_err_o),
        .ovf_err_o  (ovf_err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: compares registered status against the model state
    // built from earlier cycles, then applies this cycle's pop and push.
    always @(negedge clk) begin
        if (!rst_n) begin
            q_wr.delete();
            m_fifo.delete();
            m_done  = 1'b0;
            m_ovf   = 1'b0;
            m_sgcnt = 0;
            chk("reset_flags", {wh_ena, wh_wea, wh_vld_o, stall_o, sg_done_o, done_o,
                                seq_err_o, ovf_err_o, sg_cnt_o}, '0);
            chk("reset_buses", {wh_addra, wh_dina, wh_data_o}, '0);
        end else begin
            chk("wh_vld_o", wh_vld_o, m_fifo.size() > 0);
            chk("stall_o", stall_o, m_fifo.size() >= DEPTH - 1);
            chk("ovf_err_o", ovf_err_o, m_ovf);
            chk("done_o", done_o, m_done);
            chk("sg_cnt_o", sg_cnt_o, SW'(m_sgcnt));
            if (wh_vld_o && wh_rdy_i) begin
                if (m_fifo.size() == 0) begin
                    chk("pop_unexpected", 1, 0);
                end else begin
                    chk("wh_data_o", wh_data_o, m_fifo.pop_front());
                end
            end
            if (wh_wea) begin
                chk("wh_ena", wh_ena, 1);
                if (q_wr.size() == 0) begin
                    chk("write_unexpected", wh_addra, {AW{1'b1}});
                end else begin
                    wr_t e;
                    e = q_wr.pop_front();
                    chk("write_cycle", cyc, e.cyc);
                    chk("wh_addra", wh_addra, e.addr);
                    chk("wh_dina", wh_dina, e.data);
                    chk("sg_done_o", sg_done_o, e.sg_done);
                    chk("seq_err_o", seq_err_o, e.seq_err);
                    if (e.sg_done && m_sgcnt < NSG) m_sgcnt++;
                    if (int'(e.addr) == TOTAL - 1) m_done = 1'b1;
                    if (m_fifo.size() < DEPTH) m_fifo.push_back(e.data);
                    else m_ovf = 1'b1;
                end
            end else begin
                chk("idle_ena", wh_ena, 0);
                chk("idle_sg_done", sg_done_o, 0);
                if (q_wr.size() > 0 && q_wr[0].cyc < cyc) begin
                    chk("write_missing", q_wr[0].cyc, cyc);
                    void'(q_wr.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        row_vld_i = 1'b0;
        s_acc     = 0;
        s_in_sg   = 0;
        s_cnt     = 0;
        s_target  = 0;
        s_seq     = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    // Drives one row pulse and records what the spec says must follow.
    task automatic send_row(input logic src, input logic [NW-1:0] num, input logic [RW-1:0] res);
        wr_t e;
        row_vld_i  = 1'b1;
        src_flag_i = src;
        num_node_i = num;
        res_i      = res;
        if (s_acc < TOTAL) begin
            if (src) begin
                if (s_in_sg) s_seq = 1'b1;
                s_in_sg  = 1;
                s_cnt    = 1;
                s_target = (num == 0) ? 1 : int'(num);
            end else if (!s_in_sg) begin
                s_seq = 1'b1;
            end else begin
                s_cnt++;
            end
            e.sg_done = s_in_sg && (s_cnt == s_target);
            if (e.sg_done) s_in_sg = 0;
            e.seq_err = s_seq;
            e.addr    = AW'(s_acc);
            e.data    = {res, num, src};
            e.cyc     = cyc + 1;
            q_wr.push_back(e);
            s_acc++;
        end
        tick(1);
        row_vld_i = 1'b0;
    endtask

    function automatic logic [RW-1:0] rand_res();
        logic [RW-1:0] r;
        for (int i = 0; i < RW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [RW-1:0] lanes;
        for (int k = 0; k < NF; k++) lanes[k*DW +: DW] = DW'(k + 1);

        tick(2);
        do_reset();

        // Single-row subgraph
        wh_rdy_i = 1'b1;
        send_row(1'b1, NW'(1), lanes);
        tick(4);

        // Three-row subgraph, always ready
        send_row(1'b1, NW'(3), rand_res());
        send_row(1'b0, NW'(3), rand_res());
        send_row(1'b0, NW'(3), rand_res());
        tick(5);

        // Backpressure: five rows into a stalled FIFO, then drain
        do_reset();
        wh_rdy_i = 1'b0;
        for (int i = 0; i < 5; i++) send_row(1'b1, NW'(1), rand_res());
        tick(4);
        wh_rdy_i = 1'b1;
        tick(8);

        // Sequencing errors
        do_reset();
        send_row(1'b0, NW'(2), rand_res());
        tick(2);
        send_row(1'b1, NW'(3), rand_res());
        send_row(1'b0, NW'(3), rand_res());
        send_row(1'b1, NW'(3), rand_res());
        tick(4);

        // Address end: rows past TOTAL are ignored
        do_reset();
        for (int i = 0; i < TOTAL + 2; i++) send_row(1'b1, NW'(1), rand_res());
        tick(6);

        // Reset with two words queued mid-subgraph, then restart at address 0
        do_reset();
        wh_rdy_i = 1'b0;
        send_row(1'b1, NW'(5), rand_res());
        send_row(1'b0, NW'(5), rand_res());
        tick(3);
        do_reset();
        wh_rdy_i = 1'b1;
        send_row(1'b1, NW'(0), rand_res());
        tick(4);

        // Randomised traffic with occasional resets
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < 90; i++) begin
                wh_rdy_i = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 1) == 1)
                    send_row(($urandom_range(0, 2) == 0), NW'($urandom_range(0, 4)), rand_res());
                else
                    tick(1);
            end
            wh_rdy_i = 1'b1;
            tick(8);
        end

        chk("drain_writes", q_wr.size(), 0);
        chk("drain_fifo", m_fifo.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_wh_collector

`default_nettype wire
